tlb_assoc: RTL and testbench

TLB_ASSOC -- requirements
Module: tlb_assoc

---
 rtl/tlb_assoc_if.sv | 50 +++++
 rtl/tlb_assoc.sv | 137 +++++++++++++
 tb/tb_tlb_assoc.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_assoc_if.sv
// tlb_assoc_if: bundles the lookup, response, refill, invalidate and
// statistics signals of the fully associative TLB.
//   slave  modport: seen by the TLB (requests in, responses/stats out)
//   master modport: seen by the requester (requests out, responses/stats in)
interface tlb_assoc_if #(
    parameter int VPN_BITS  = 20,
    parameter int PFN_BITS  = 20,
    parameter int ASID_BITS = 8
) ();
    logic                 lk_valid;
    logic [VPN_BITS-1:0]  lk_vpn;
    logic [ASID_BITS-1:0] lk_asid;

    logic                 rsp_valid;
    logic                 rsp_hit;
    logic [PFN_BITS-1:0]  rsp_pfn;

    logic                 rf_valid;
    logic                 rf_ready;
    logic [VPN_BITS-1:0]  rf_vpn;
    logic [ASID_BITS-1:0] rf_asid;
    logic [PFN_BITS-1:0]  rf_pfn;
    logic                 rf_global;

    logic                 inv_valid;
    logic [1:0]           inv_mode;
    logic [VPN_BITS-1:0]  inv_vpn;
    logic [ASID_BITS-1:0] inv_asid;

    logic [31:0]          hit_cnt;
    logic [31:0]          miss_cnt;

    modport slave (
        input  lk_valid, lk_vpn, lk_asid,
        output rsp_valid, rsp_hit, rsp_pfn,
        input  rf_valid, rf_vpn, rf_asid, rf_pfn, rf_global,
        output rf_ready,
        input  inv_valid, inv_mode, inv_vpn, inv_asid,
        output hit_cnt, miss_cnt
    );

    modport master (
        output lk_valid, lk_vpn, lk_asid,
        input  rsp_valid, rsp_hit, rsp_pfn,
        output rf_valid, rf_vpn, rf_asid, rf_pfn, rf_global,
        input  rf_ready,
        output inv_valid, inv_mode, inv_vpn, inv_asid,
        input  hit_cnt, miss_cnt
    );
endinterface

// File: rtl/tlb_assoc.sv
// tlb_assoc: fully associative TLB with ASID tagging and global entries.
//   clk    sole clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    tlb_assoc_if.slave: registered 1-cycle lookup, refill with
//          rf_ready = !inv_valid, invalidate (all / ASID / VPN), and
//          saturating hit/miss counters.
// Replacement: in-place overwrite on match, else lowest invalid entry,
// else round-robin pointer.
module tlb_assoc #(
    parameter int          VPN_BITS  = 20,
    parameter int          PFN_BITS  = 20,
    parameter int          ASID_BITS = 8,
    parameter int unsigned ENTRIES   = 8
) (
    input logic        clk,
    input logic        rst_n,
    tlb_assoc_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]   valid;
    logic [VPN_BITS-1:0]  tag_arr  [ENTRIES];
    logic [ASID_BITS-1:0] asid_arr [ENTRIES];
    logic [PFN_BITS-1:0]  pfn_arr  [ENTRIES];
    logic [ENTRIES-1:0]   glob;
    logic [IDX_W-1:0]     replace_ptr;

    logic                 rsp_valid_q;
    logic                 rsp_hit_q;
    logic [PFN_BITS-1:0]  rsp_pfn_q;
    logic [31:0]          hit_cnt_q;
    logic [31:0]          miss_cnt_q;

    logic                 lk_hit;
    logic [IDX_W-1:0]     lk_idx;
    logic                 rf_hit;
    logic [IDX_W-1:0]     rf_idx;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     wr_idx;
    logic [ENTRIES-1:0]   inv_sel;

    assign bus.rf_ready  = !bus.inv_valid;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_pfn   = rsp_pfn_q;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;

    // Priority searches: the first hit in ascending order wins, so the
    // lowest matching / lowest free index is selected.
    always_comb begin
        lk_hit     = 1'b0;
        lk_idx     = '0;
        rf_hit     = 1'b0;
        rf_idx     = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!lk_hit && valid[i] && tag_arr[i] == bus.lk_vpn &&
                (glob[i] || asid_arr[i] == bus.lk_asid)) begin
                lk_hit = 1'b1;
                lk_idx = i[IDX_W-1:0];
            end
            if (!rf_hit && valid[i] && tag_arr[i] == bus.rf_vpn &&
                (glob[i] || asid_arr[i] == bus.rf_asid)) begin
                rf_hit = 1'b1;
                rf_idx = i[IDX_W-1:0];
            end
            if (!free_found && !valid[i]) begin
                free_found = 1'b1;
                free_idx   = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        wr_idx = replace_ptr;
        if (rf_hit)
            wr_idx = rf_idx;
        else if (free_found)
            wr_idx = free_idx;
    end

    always_comb begin
        inv_sel = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            case (bus.inv_mode)
                2'd0:    inv_sel[i] = 1'b1;
                2'd1:    inv_sel[i] = !glob[i] && asid_arr[i] == bus.inv_asid;
                2'd2:    inv_sel[i] = tag_arr[i] == bus.inv_vpn;
                default: inv_sel[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid       <= '0;
            replace_ptr <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_pfn_q   <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= bus.lk_valid;
            rsp_hit_q   <= bus.lk_valid && lk_hit;
            rsp_pfn_q   <= (bus.lk_valid && lk_hit) ? pfn_arr[lk_idx] : '0;

            // Counters advance on the edge that registers the response,
            // so they already include it while rsp_valid is high.
            if (bus.lk_valid) begin
                if (lk_hit) begin
                    if (hit_cnt_q != '1)
                        hit_cnt_q <= hit_cnt_q + 32'd1;
                end else begin
                    if (miss_cnt_q != '1)
                        miss_cnt_q <= miss_cnt_q + 32'd1;
                end
            end

            // Invalidate wins; a concurrent refill is held off via rf_ready.
            if (bus.inv_valid) begin
                valid <= valid & ~inv_sel;
            end else if (bus.rf_valid) begin
                valid[wr_idx]    <= 1'b1;
                glob[wr_idx]     <= bus.rf_global;
                tag_arr[wr_idx]  <= bus.rf_vpn;
                asid_arr[wr_idx] <= bus.rf_asid;
                pfn_arr[wr_idx]  <= bus.rf_pfn;
                if (!rf_hit && !free_found)
                    replace_ptr <= replace_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tlb_assoc.sv
// tb_tlb_assoc: scoreboard bench for tlb_assoc. The driver updates a
// behavioural table model and queues the expected response of every
// lookup; a monitor pops and compares whenever rsp_valid is seen.
module tb_tlb_assoc;
    localparam int E = 8;

    typedef struct {
        logic        hit;
        logic [19:0] pfn;
        logic [31:0] hc;
        logic [31:0] mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tlb_assoc_if #(.VPN_BITS(20), .PFN_BITS(20), .ASID_BITS(8)) bus ();

    tlb_assoc #(.VPN_BITS(20), .PFN_BITS(20), .ASID_BITS(8), .ENTRIES(E)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    // Reference model: a plain table of entries with a round-robin victim.
    bit          m_v    [E];
    logic [19:0] m_tag  [E];
    logic [7:0]  m_asid [E];
    logic [19:0] m_pfn  [E];
    bit          m_g    [E];
    int          m_ptr;
    logic [31:0] m_hc, m_mc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_find(input logic [19:0] vpn, input logic [7:0] asid);
        for (int i = 0; i < E; i++)
            if (m_v[i] && m_tag[i] == vpn && (m_g[i] || m_asid[i] == asid))
                return i;
        return -1;
    endfunction

    task automatic idle();
        bus.lk_valid  = 1'b0;
        bus.rf_valid  = 1'b0;
        bus.inv_valid = 1'b0;
        bus.inv_mode  = 2'd0;
    endtask

    task automatic lookup(input logic [19:0] vpn, input logic [7:0] asid);
        bus.lk_valid = 1'b1;
        bus.lk_vpn   = vpn;
        bus.lk_asid  = asid;
    endtask

    task automatic refill(input logic [19:0] vpn, input logic [7:0] asid,
                          input logic [19:0] pfn, input logic g);
        bus.rf_valid  = 1'b1;
        bus.rf_vpn    = vpn;
        bus.rf_asid   = asid;
        bus.rf_pfn    = pfn;
        bus.rf_global = g;
    endtask

    // Called just after a falling edge with inputs set: applies the
    // upcoming rising edge to the model, then waits for the next falling edge.
    task automatic step();
        int   idx;
        exp_t e;
        #1;
        check("rf_ready", {31'd0, bus.rf_ready}, {31'd0, !bus.inv_valid});
        if (!rst_n) begin
            for (int i = 0; i < E; i++) m_v[i] = 0;
            m_ptr = 0;
            m_hc  = 0;
            m_mc  = 0;
            exp_q.delete();
        end else begin
            if (bus.lk_valid) begin
                idx = m_find(bus.lk_vpn, bus.lk_asid);
                if (idx >= 0) begin
                    if (m_hc != 32'hFFFF_FFFF) m_hc++;
                    e.hit = 1'b1;
                    e.pfn = m_pfn[idx];
                end else begin
                    if (m_mc != 32'hFFFF_FFFF) m_mc++;
                    e.hit = 1'b0;
                    e.pfn = '0;
                end
                e.hc = m_hc;
                e.mc = m_mc;
                exp_q.push_back(e);
            end
            if (bus.inv_valid) begin
                for (int i = 0; i < E; i++) begin
                    if (bus.inv_mode == 2'd0 ||
                        (bus.inv_mode == 2'd1 && !m_g[i] && m_asid[i] == bus.inv_asid) ||
                        (bus.inv_mode == 2'd2 && m_tag[i] == bus.inv_vpn))
                        m_v[i] = 0;
                end
            end else if (bus.rf_valid) begin
                idx = m_find(bus.rf_vpn, bus.rf_asid);
                if (idx < 0)
                    for (int i = E - 1; i >= 0; i--)
                        if (!m_v[i]) idx = i;
                if (idx < 0) begin
                    idx   = m_ptr;
                    m_ptr = (m_ptr + 1) % E;
                end
                m_v[idx]    = 1;
                m_tag[idx]  = bus.rf_vpn;
                m_asid[idx] = bus.rf_asid;
                m_pfn[idx]  = bus.rf_pfn;
                m_g[idx]    = bus.rf_global;
            end
        end
        @(negedge clk);
    endtask

    // Single lookup cycle followed by a direct check of the response.
    task automatic probe(input string name, input logic [19:0] vpn,
                         input logic [7:0] asid, input logic hit, input logic [19:0] pfn);
        idle();
        lookup(vpn, asid);
        step();
        idle();
        check({name, "_hit"}, {31'd0, bus.rsp_hit}, {31'd0, hit});
        check({name, "_pfn"}, {12'd0, bus.rsp_pfn}, {12'd0, pfn});
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Monitor: compares each presented response against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_hit", {31'd0, bus.rsp_hit}, {31'd0, e.hit});
                    check("sb_pfn", {12'd0, bus.rsp_pfn}, {12'd0, e.pfn});
                    check("sb_hit_cnt", bus.hit_cnt, e.hc);
                    check("sb_miss_cnt", bus.miss_cnt, e.mc);
                end
            end else begin
                check("idle_hit", {31'd0, bus.rsp_hit}, 32'd0);
                check("idle_pfn", {12'd0, bus.rsp_pfn}, 32'd0);
            end
        end
    end

    initial begin
        idle();
        bus.lk_vpn = '0; bus.lk_asid = '0;
        bus.rf_vpn = '0; bus.rf_asid = '0; bus.rf_pfn = '0; bus.rf_global = 1'b0;
        bus.inv_vpn = '0; bus.inv_asid = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("reset_hit_cnt", bus.hit_cnt, 32'd0);
        check("reset_miss_cnt", bus.miss_cnt, 32'd0);

        // Basic refill and lookup, ASID mismatch, global entry.
        refill(20'h12345, 8'd3, 20'hABCDE, 1'b0); step(); idle();
        probe("basic", 20'h12345, 8'd3, 1'b1, 20'hABCDE);
        check("basic_hit_cnt", bus.hit_cnt, 32'd1);
        probe("asid_miss", 20'h12345, 8'd4, 1'b0, 20'h0);
        check("asid_miss_cnt", bus.miss_cnt, 32'd1);
        refill(20'h22222, 8'd3, 20'h11111, 1'b1); step(); idle();
        probe("global", 20'h22222, 8'd4, 1'b1, 20'h11111);

        // Fill all entries, then round-robin replacement.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            refill(20'h100 + 20'(i), 8'd3, 20'h500 + 20'(i), 1'b0);
            step();
        end
        idle();
        probe("evict_first", 20'h100, 8'd3, 1'b0, 20'h0);
        probe("ninth", 20'h108, 8'd3, 1'b1, 20'h508);
        refill(20'h200, 8'd3, 20'h600, 1'b0); step(); idle();
        probe("ptr1_victim", 20'h101, 8'd3, 1'b0, 20'h0);
        probe("ptr1_keep", 20'h102, 8'd3, 1'b1, 20'h502);

        // Same (vpn, asid) twice: overwrite in place, pointer untouched.
        refill(20'h105, 8'd3, 20'h1, 1'b0); step();
        refill(20'h105, 8'd3, 20'h2, 1'b0); step(); idle();
        probe("overwrite", 20'h105, 8'd3, 1'b1, 20'h2);
        refill(20'h300, 8'd3, 20'h700, 1'b0); step(); idle();
        probe("ptr2_victim", 20'h102, 8'd3, 1'b0, 20'h0);
        probe("ptr2_keep", 20'h103, 8'd3, 1'b1, 20'h503);

        // Invalidate by ASID colliding with a refill.
        do_reset();
        refill(20'h10, 8'd3, 20'h10, 1'b0); step();
        refill(20'h20, 8'd3, 20'h20, 1'b1); step();
        refill(20'h30, 8'd4, 20'h30, 1'b0); step();
        refill(20'h40, 8'd3, 20'h40, 1'b0);
        bus.inv_valid = 1'b1; bus.inv_mode = 2'd1; bus.inv_asid = 8'd3;
        #1 check("collide_rf_ready", {31'd0, bus.rf_ready}, 32'd0);
        step();
        bus.inv_valid = 1'b0;
        lookup(20'h10, 8'd3);
        step(); idle();
        probe("inv_asid", 20'h10, 8'd3, 1'b0, 20'h0);
        probe("inv_global", 20'h20, 8'd3, 1'b1, 20'h20);
        probe("inv_other", 20'h30, 8'd4, 1'b1, 20'h30);
        probe("held_refill", 20'h40, 8'd3, 1'b1, 20'h40);

        // Reset while a lookup is in flight.
        lookup(20'h30, 8'd4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; idle();
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_hit_cnt", bus.hit_cnt, 32'd0);
        check("rst_miss_cnt", bus.miss_cnt, 32'd0);
        probe("rst_miss_a", 20'h30, 8'd4, 1'b0, 20'h0);
        probe("rst_miss_b", 20'h20, 8'd3, 1'b0, 20'h0);

        // Randomized traffic on a small address set to force collisions.
        for (int n = 0; n < 600; n++) begin
            idle();
            rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 9) < 6) lookup(20'($urandom_range(0, 6)), 8'($urandom_range(0, 2)));
            if ($urandom_range(0, 9) < 4)
                refill(20'($urandom_range(0, 6)), 8'($urandom_range(0, 2)),
                       20'($urandom), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 9) == 0) begin
                bus.inv_valid = 1'b1;
                bus.inv_mode  = 2'($urandom_range(0, 3));
                bus.inv_vpn   = 20'($urandom_range(0, 6));
                bus.inv_asid  = 8'($urandom_range(0, 2));
            end
            step();
        end
        rst_n = 1'b1;
        idle();
        step();
        step();
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
